// File: rtl/mem_arb_pkg.sv
// Shared types and the round-robin pick function for the memory-port arbiter.
package mem_arb_pkg;

    localparam int unsigned MAX_MASTERS = 8;
    localparam int unsigned CNT_W       = 32;

    typedef logic [2:0] id_t;

    typedef struct packed {
        logic found;
        id_t  idx;
    } pick_t;

    // Requests above N_MASTERS are zero, so a mod-8 search equals a mod-N search.
    function automatic pick_t rr_pick(input logic [MAX_MASTERS-1:0] req, input id_t prio);
        pick_t r;
        id_t   idx;
        r = '0;
        for (int unsigned i = 0; i < MAX_MASTERS; i++) begin
            idx = prio + id_t'(i);
            if (!r.found && req[idx]) begin
                r.found = 1'b1;
                r.idx   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_arb_id_fifo.sv
// Outstanding-transaction ID FIFO; full/empty derived from wrap-bit pointers.
module mem_arb_id_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned NE = 2 ** AW;

    logic [WIDTH-1:0] mem_q [NE];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW-1:0]    fill;

    assign fill    = wr_ptr_q - rd_ptr_q;
    assign full_o  = (fill == PW'(DEPTH));
    assign empty_o = (fill == '0);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < NE; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_i && !full_o) begin
                mem_q[wr_ptr_q[AW-1:0]] <= data_i;
                wr_ptr_q                <= wr_ptr_q + PW'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one req/gnt/rvalid memory port among N masters.
// Optional per-master grant counters are built when MEM_ARB_STATS_EN is defined.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned N_MASTERS = 2,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_OUTST = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [N_MASTERS-1:0]                   m_req_i,
    input  logic [N_MASTERS-1:0][ADDR_W-1:0]       m_addr_i,
    input  logic [N_MASTERS-1:0]                   m_we_i,
    input  logic [N_MASTERS-1:0][DATA_W/8-1:0]     m_be_i,
    input  logic [N_MASTERS-1:0][DATA_W-1:0]       m_wdata_i,
    output logic [N_MASTERS-1:0]                   m_gnt_o,
    output logic [N_MASTERS-1:0]                   m_rvalid_o,
    output logic [DATA_W-1:0]                      m_rdata_o,
    output logic                                   s_req_o,
    output logic [ADDR_W-1:0]                      s_addr_o,
    output logic                                   s_we_o,
    output logic [DATA_W/8-1:0]                    s_be_o,
    output logic [DATA_W-1:0]                      s_wdata_o,
    input  logic                                   s_gnt_i,
    input  logic                                   s_rvalid_i,
    input  logic [DATA_W-1:0]                      s_rdata_i,
    output logic                                   err_o,
    output logic [N_MASTERS-1:0][CNT_W-1:0]        grant_cnt_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    id_t                    prio_q;
    logic                   err_q;
    pick_t                  pick;
    logic [MAX_MASTERS-1:0] req_ext;
    logic                   handshake;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    id_t                    head_id;

    assign req_ext   = MAX_MASTERS'(m_req_i);
    assign pick      = rr_pick(req_ext, prio_q);
    // Full blocks requests regardless of a same-cycle pop: no rvalid->req path.
    assign s_req_o   = pick.found && !fifo_full;
    assign handshake = s_req_o && s_gnt_i;
    assign pop       = s_rvalid_i && !fifo_empty;
    assign m_rdata_o = s_rdata_i;
    assign err_o     = err_q;

    // Winner's request fields onto the slave channel, zeros when idle.
    always_comb begin
        s_addr_o  = '0;
        s_we_o    = 1'b0;
        s_be_o    = '0;
        s_wdata_o = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            if (pick.found && (pick.idx == id_t'(i))) begin
                s_addr_o  = m_addr_i[i];
                s_we_o    = m_we_i[i];
                s_be_o    = m_be_i[i];
                s_wdata_o = m_wdata_i[i];
            end
        end
    end

    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        for (int unsigned i = 0; i < N_MASTERS; i++) begin
            m_gnt_o[i]    = handshake && (pick.idx == id_t'(i));
            m_rvalid_o[i] = pop && (head_id == id_t'(i));
        end
    end

    mem_arb_id_fifo #(
        .DEPTH (MAX_OUTST),
        .WIDTH ($bits(id_t))
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .pop_i   (pop),
        .data_i  (pick.idx),
        .head_o  (head_id),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (handshake) begin
                prio_q <= (pick.idx == id_t'(N_MASTERS - 1)) ? id_t'(0) : pick.idx + id_t'(1);
            end
            if (s_rvalid_i && fifo_empty) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [N_MASTERS-1:0][CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < N_MASTERS; i++) begin
                if (m_gnt_o[i]) begin
                    cnt_q[i] <= cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign grant_cnt_o = cnt_q;
`else
    assign grant_cnt_o = '0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (N_MASTERS=4, MAX_OUTST=2).
module tb_mem_port_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic                     clk;
    logic                     rst_n;
    logic [N-1:0]             m_req;
    logic [N-1:0][AW-1:0]     m_addr;
    logic [N-1:0]             m_we;
    logic [N-1:0][DW/8-1:0]   m_be;
    logic [N-1:0][DW-1:0]     m_wdata;
    logic [N-1:0]             m_gnt;
    logic [N-1:0]             m_rvalid;
    logic [DW-1:0]            m_rdata;
    logic                     s_req;
    logic [AW-1:0]            s_addr;
    logic                     s_we;
    logic [DW/8-1:0]          s_be;
    logic [DW-1:0]            s_wdata;
    logic                     s_gnt;
    logic                     s_rvalid;
    logic [DW-1:0]            s_rdata;
    logic                     err;
    logic [N-1:0][31:0]       gcnt;

    int n_cmp  = 0;
    int n_fail = 0;

    mem_port_arbiter #(
        .N_MASTERS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_OUTST (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .m_req_i     (m_req),
        .m_addr_i    (m_addr),
        .m_we_i      (m_we),
        .m_be_i      (m_be),
        .m_wdata_i   (m_wdata),
        .m_gnt_o     (m_gnt),
        .m_rvalid_o  (m_rvalid),
        .m_rdata_o   (m_rdata),
        .s_req_o     (s_req),
        .s_addr_o    (s_addr),
        .s_we_o      (s_we),
        .s_be_o      (s_be),
        .s_wdata_o   (s_wdata),
        .s_gnt_i     (s_gnt),
        .s_rvalid_i  (s_rvalid),
        .s_rdata_i   (s_rdata),
        .err_o       (err),
        .grant_cnt_o (gcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0]  exp_g;
        logic [3:0]  exp_r;
        logic [31:0] exp_cnt;

        rst_n    = 1'b0;
        m_req    = '0;
        m_we     = '0;
        m_be     = '0;
        m_wdata  = '0;
        m_addr[0] = 32'h100;
        m_addr[1] = 32'h200;
        m_addr[2] = 32'h300;
        m_addr[3] = 32'h400;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;

        // Reset state and combinational request path while in reset
        #2;
        chk("rst_s_req_idle", 64'(s_req), 64'h0);
        chk("rst_gnt", 64'(m_gnt), 64'h0);
        chk("rst_rvalid", 64'(m_rvalid), 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        chk("rst_cnt", 64'(gcnt[0]) | 64'(gcnt[3]), 64'h0);
        m_req = 4'b0001;
        #1;
        chk("rst_s_req_busy", 64'(s_req), 64'h1);
        chk("rst_s_addr", 64'(s_addr), 64'h100);
        m_req = '0;
        #1;
        chk("idle_s_addr_zero", 64'(s_addr), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single master read
        @(negedge clk);
        m_req = 4'b0001; s_gnt = 1'b1;
        #1;
        chk("single_gnt", 64'(m_gnt), 64'h1);
        chk("single_addr", 64'(s_addr), 64'h100);
        chk("single_we", 64'(s_we), 64'h0);
        @(negedge clk);
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEADBEEF;
        #1;
        chk("single_rvalid", 64'(m_rvalid), 64'h1);
        chk("single_rdata", 64'(m_rdata), 64'hDEADBEEF);
        chk("single_sreq_idle", 64'(s_req), 64'h0);
        @(negedge clk);
        s_rvalid = 1'b0;
        #1;
        chk("single_rvalid_low", 64'(m_rvalid), 64'h0);
        chk("single_no_err", 64'(err), 64'h0);

        // Ordering, outstanding limit and simultaneous push/pop (prio now 1)
        @(negedge clk);
        m_req = 4'b0101; s_gnt = 1'b1;
        m_we[0] = 1'b1; m_be[0] = 4'hF; m_wdata[0] = 32'hCAFE;
        #1;
        chk("ord_gnt_m2", 64'(m_gnt), 64'h4);
        chk("ord_addr_m2", 64'(s_addr), 64'h300);
        @(negedge clk);
        m_req = 4'b0001;
        #1;
        chk("ord_gnt_m0", 64'(m_gnt), 64'h1);
        chk("ord_we_m0", 64'(s_we), 64'h1);
        chk("ord_be_m0", 64'(s_be), 64'hF);
        chk("ord_wdata_m0", 64'(s_wdata), 64'hCAFE);
        @(negedge clk);
        m_req = 4'b0010; m_we[0] = 1'b0;
        s_rvalid = 1'b1; s_rdata = 32'h11;
        #1;
        chk("full_sreq_blocked", 64'(s_req), 64'h0);
        chk("full_gnt_none", 64'(m_gnt), 64'h0);
        chk("ord_rvalid_m2", 64'(m_rvalid), 64'h4);
        chk("ord_rdata_11", 64'(m_rdata), 64'h11);
        @(negedge clk);
        s_rdata = 32'h22;
        #1;
        chk("limit_sreq_back", 64'(s_req), 64'h1);
        chk("pushpop_gnt_m1", 64'(m_gnt), 64'h2);
        chk("pushpop_addr_m1", 64'(s_addr), 64'h200);
        chk("ord_rvalid_m0", 64'(m_rvalid), 64'h1);
        chk("ord_rdata_22", 64'(m_rdata), 64'h22);
        @(negedge clk);
        m_req = '0; s_rdata = 32'h33;
        #1;
        chk("pushpop_rvalid_m1", 64'(m_rvalid), 64'h2);
        chk("pushpop_sreq_idle", 64'(s_req), 64'h0);
        @(negedge clk);
        s_rvalid = 1'b0;

        // Fill two outstanding, then reset mid-flight (prio now 2)
        m_req = 4'b0001;
        #1;
        chk("fill_gnt_a", 64'(m_gnt), 64'h1);
        @(negedge clk);
        #1;
        chk("fill_gnt_b", 64'(m_gnt), 64'h1);
        @(negedge clk);
        m_req = 4'b1010;
        #1;
        chk("fill_blocked", 64'(s_req), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("midrst_sreq", 64'(s_req), 64'h1);
        chk("midrst_addr_lowest", 64'(s_addr), 64'h200);
        chk("midrst_err", 64'(err), 64'h0);
        chk("midrst_cnt", 64'(gcnt[0]), 64'h0);
        @(negedge clk);
        rst_n = 1'b1; s_rvalid = 1'b1; s_rdata = 32'h44;
        #1;
        chk("post_rst_gnt_m1", 64'(m_gnt), 64'h2);
        chk("orphan_no_rvalid", 64'(m_rvalid), 64'h0);
        @(negedge clk);
        m_req = '0; s_rdata = 32'h55;
        #1;
        chk("orphan_err_set", 64'(err), 64'h1);
        chk("post_rst_rvalid_m1", 64'(m_rvalid), 64'h2);
        @(negedge clk);
        s_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("orphan_err_held", 64'(err), 64'h1);
        chk("orphan_prio_after", 64'(m_rvalid), 64'h0);
        rst_n = 1'b0;
        #1;
        chk("err_cleared_rst", 64'(err), 64'h0);

        // Fairness: all four request, slave always grants and responds
        @(negedge clk);
        rst_n = 1'b1; m_req = 4'b1111; s_gnt = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            s_rvalid = (k > 0);
            s_rdata  = 32'(k);
            #1;
            exp_g = 4'b0001 << (k % 4);
            exp_r = (k > 0) ? (4'b0001 << ((k - 1) % 4)) : 4'b0000;
            chk($sformatf("fair_gnt_%0d", k), 64'(m_gnt), 64'(exp_g));
            chk($sformatf("fair_rvalid_%0d", k), 64'(m_rvalid), 64'(exp_r));
        end
        @(negedge clk);
        m_req = '0;
        #1;
        chk("fair_last_rvalid", 64'(m_rvalid), 64'h8);
`ifdef MEM_ARB_STATS_EN
        exp_cnt = 32'd2;
`else
        exp_cnt = 32'd0;
`endif
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("fair_cnt_%0d", i), 64'(gcnt[i]), 64'(exp_cnt));
        end
        @(negedge clk);
        s_rvalid = 1'b0; s_gnt = 1'b0;
        #1;
        chk("fair_no_err", 64'(err), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter that lets `N_MASTERS` zeroriscy-style memory ports share one `mem_mod` port. It uses the req/gnt/rvalid protocol. It sits between the cores' instruction or data ports and a single memory instance. It tracks outstanding transactions in an ID FIFO so each rvalid returns only to the master that issued the request.

## Interface
- `N_MASTERS`, 2: number of requesting ports, 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, a multiple of 8.
- `MAX_OUTST`, 2: ID FIFO depth, power of two, 1..8.
- `clk_i` input 1: clock.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `m_req_i` input N_MASTERS: per-master request.
- `m_addr_i` input N_MASTERS×ADDR_W: per-master address.
- `m_we_i` input N_MASTERS: per-master write enable.
- `m_be_i` input N_MASTERS×DATA_W/8: per-master byte enables.
- `m_wdata_i` input N_MASTERS×DATA_W: per-master write data.
- `m_gnt_o` output N_MASTERS: per-master grant, one-hot or zero.
- `m_rvalid_o` output N_MASTERS: per-master response valid, one-hot or zero.
- `m_rdata_o` output DATA_W: response data, broadcast to all masters.
- `s_req_o`, `s_addr_o`, `s_we_o`, `s_be_o`, `s_wdata_o` output: slave request channel.
- `s_gnt_i` input 1: slave grant.
- `s_rvalid_i` input 1: slave response valid.
- `s_rdata_i` input DATA_W: slave response data.
- `err_o` output 1: sticky flag, set by an unexpected rvalid.
- `grant_cnt_o` output N_MASTERS×32: per-master grant counters (see Configuration).

## Operation
- **Winner selection:** combinational. Search starts at `prio_q` and goes upward modulo N_MASTERS. The first master with `m_req_i` set wins.
- **Slave request:** `s_req_o` = any request && !fifo_full. The winner's addr/we/be/wdata drive the slave channel. When there is no winner, the channel drives zeros.
- **Grant:** `m_gnt_o[w]` = `s_req_o && s_gnt_i`. At most one bit is set.
- **On a handshake (req && gnt):**
  - push winner ID `w` into the ID FIFO;
  - set `prio_q` to (w+1) mod N_MASTERS.
- **Response:** on `s_rvalid_i` with the FIFO non-empty, pop the head ID `h` and assert `m_rvalid_o[h]`. `m_rdata_o` = `s_rdata_i` unconditionally.
- **Unexpected rvalid:** `s_rvalid_i` with the FIFO empty is dropped. No master sees rvalid, and `err_o` is set. `err_o` clears only on reset.
- **FIFO full:** requests are blocked, even if a pop happens in the same cycle. This keeps any combinational path from `s_rvalid_i` to `s_req_o` out of the design.
- **Simultaneous push and pop** when the FIFO is not full: both happen and occupancy is unchanged.
- **Held requests:** a master holds req, addr and wdata until it sees gnt. The arbiter never drops or reorders a granted transaction. Responses are in order.

## Timing
- Gnt path: zero added latency. `s_gnt_i` reaches `m_gnt_o` combinationally in the same cycle.
- Response path: zero added latency. rvalid and rdata pass through combinationally.
- State is `prio_q`, the FIFO and `err_o`. All update on the rising edge of `clk_i`.
- **Reset values:**
  - `prio_q`=0, FIFO empty, `err_o`=0, counters 0.
  - Outputs in reset: `s_req_o`=0 only when no master requests; outputs are purely combinational from inputs and state.
- **Reset mid-operation:** outstanding IDs are discarded. A later orphan rvalid sets `err_o` after reset release.
- Wrap-around: FIFO pointers are log2(MAX_OUTST)+1 bits, with a wrap bit for the full/empty distinction. `prio_q` wraps from N_MASTERS-1 to 0.

## Configuration
- `MEM_ARB_STATS_EN` defined: one 32-bit counter per master, incremented on each of that master's handshakes. Counters wrap at 2^32-1 → 0. Values appear on `grant_cnt_o`.
- `MEM_ARB_STATS_EN` undefined: no counter flops are built and `grant_cnt_o` is tied to 0. The port list is identical in both builds.

## Structure
- Package `mem_arb_pkg`:
  - `MAX_MASTERS`=8;
  - `id_t` typedef, `logic [2:0]`;
  - function `rr_pick(req, prio)` returning winner index and found flag.
- Sub-module `mem_arb_id_fifo`: parametrised depth and width, push/pop/full/empty/head. It is the natural split and is used only here.

## Test plan
- **Single master:** N=2, master 0 reads 0x100 with gnt=1 and rvalid one cycle later, rdata 0xDEADBEEF → `m_gnt_o`=01, then `m_rvalid_o`=01 with `m_rdata_o`=0xDEADBEEF; `m_rvalid_o[1]` never set.
- **Fairness:** N=4, all four requesting continuously with gnt always 1 → grant order 0,1,2,3,0,1. After 8 handshakes each counter reads 2 (stats build).
- **Outstanding limit:** MAX_OUTST=2, slave gnt=1, rvalid withheld → two grants, then `s_req_o`=0. After one rvalid, `s_req_o` returns the next cycle.
- **Ordering:** master 2 then master 0 granted, rvalids with rdata 0x11 then 0x22 → master 2 receives 0x11, then master 0 receives 0x22.
- **Orphan response:** `s_rvalid_i` pulse with FIFO empty → no `m_rvalid_o`, `err_o`=1 and held until `rst_ni` is low.
- **Reset mid-flight:** assert `rst_ni`=0 with 2 outstanding → FIFO empty, `prio_q`=0, and the first grant after release goes to the lowest-index requester.
